// File: rtl/led_pattern_gen_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes, direction flags
// and the prescaler width helper.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK   = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_BREATHE = 2'd3
  } led_mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } pos_dir_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } duty_dir_e;

  // Bits needed to count up to the larger of the two terminal values (at least 1).
  function automatic int cnt_width(input int tick_div, input int breathe_div);
    int max_div;
    int w;
    max_div = (tick_div > breathe_div) ? tick_div : breathe_div;
    w = $clog2(max_div + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle between the board-level controller and the LED generator.
interface led_pattern_gen_if #(
  parameter int NUM_LED = 4
);
  logic               en;
  logic [1:0]         mode;
  logic [NUM_LED-1:0] led;
  logic               tick;

  modport master (output en, output mode, input led, input tick);
  modport slave  (input en, input mode, output led, output tick);
endinterface

// File: rtl/led_pattern_gen_prescaler.sv
// Terminal-count divider: counts 0..i_term while enabled and flags the wrap cycle.
module led_prescaler #(
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_step
);

  logic [CNT_W-1:0] r_cnt;

  assign o_step = i_en && (r_cnt >= i_term);

  // Count register: synchronous clear wins, hold while disabled, wrap at terminal.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt >= i_term) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Parametrised LED driver with blink, chase, bounce and PWM breathe patterns,
// stepped by an internal prescaler; LED and TICK are registered.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int NUM_LED     = 4,
  parameter int TICK_DIV    = 124999999,
  parameter int BREATHE_DIV = 488280,
  parameter int PWM_BITS    = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  led_pattern_gen_if.slave   bus
);

  localparam int                  CNT_W        = cnt_width(TICK_DIV, BREATHE_DIV);
  localparam logic [CNT_W-1:0]    TICK_TERM    = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0]    BREATHE_TERM = CNT_W'(BREATHE_DIV);
  localparam logic [PWM_BITS-1:0] DUTY_MAX     = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] DUTY_ONE     = PWM_BITS'(1);
  localparam logic [NUM_LED-1:0]  LED_BIT0     = NUM_LED'(1);

  led_mode_e             r_mode;
  logic [NUM_LED-1:0]    r_led;
  logic                  r_tick;
  pos_dir_e              r_pos_dir;
  logic [PWM_BITS-1:0]   r_duty;
  duty_dir_e             r_duty_dir;
  logic [PWM_BITS-1:0]   r_pwm;

  led_mode_e             w_mode_nxt;
  logic [NUM_LED-1:0]    w_led_nxt;
  logic                  w_tick_nxt;
  pos_dir_e              w_pos_dir_nxt;
  logic [PWM_BITS-1:0]   w_duty_nxt;
  duty_dir_e             w_duty_dir_nxt;
  logic [PWM_BITS-1:0]   w_pwm_nxt;

  logic                  w_mode_chg;
  logic [CNT_W-1:0]      w_term;
  logic                  w_presc_step;
  logic                  w_step;

  assign w_mode_chg = (bus.mode != r_mode);
  assign w_term     = (r_mode == MODE_BREATHE) ? BREATHE_TERM : TICK_TERM;
  // A mode change restarts the period, so a coincident terminal count is dropped.
  assign w_step     = w_presc_step && !w_mode_chg;

  led_prescaler #(
    .CNT_W (CNT_W)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_mode_chg),
    .i_en    (bus.en),
    .i_term  (w_term),
    .o_step  (w_presc_step)
  );

  // Next-state logic: mode init on change, otherwise advance the active pattern.
  always_comb begin
    w_mode_nxt     = r_mode;
    w_led_nxt      = r_led;
    w_tick_nxt     = 1'b0;
    w_pos_dir_nxt  = r_pos_dir;
    w_duty_nxt     = r_duty;
    w_duty_dir_nxt = r_duty_dir;
    w_pwm_nxt      = r_pwm;

    if (w_mode_chg) begin
      w_mode_nxt = led_mode_e'(bus.mode);
      w_pwm_nxt  = '0;
      case (led_mode_e'(bus.mode))
        MODE_CHASE, MODE_BOUNCE: begin
          w_led_nxt     = LED_BIT0;
          w_pos_dir_nxt = DIR_LEFT;
        end
        MODE_BREATHE: begin
          w_led_nxt      = '0;
          w_duty_nxt     = '0;
          w_duty_dir_nxt = DIR_UP;
        end
        default: begin
          w_led_nxt = '0;
        end
      endcase
    end else begin
      w_tick_nxt = w_step;
      if (bus.en) begin
        w_pwm_nxt = r_pwm + DUTY_ONE;
      end else begin
        w_pwm_nxt = r_pwm;
      end

      case (r_mode)
        MODE_BLINK: begin
          if (w_step) begin
            w_led_nxt = ~r_led;
          end else begin
            w_led_nxt = r_led;
          end
        end
        MODE_CHASE: begin
          if (w_step) begin
            w_led_nxt = {r_led[NUM_LED-2:0], r_led[NUM_LED-1]};
          end else begin
            w_led_nxt = r_led;
          end
        end
        MODE_BOUNCE: begin
          if (!w_step) begin
            w_led_nxt = r_led;
          end else if (r_pos_dir == DIR_LEFT) begin
            w_led_nxt = {r_led[NUM_LED-2:0], 1'b0};
            if (r_led[NUM_LED-2] || r_led[NUM_LED-1]) begin
              w_pos_dir_nxt = DIR_RIGHT;
            end else begin
              w_pos_dir_nxt = DIR_LEFT;
            end
          end else begin
            w_led_nxt = {1'b0, r_led[NUM_LED-1:1]};
            if (r_led[1] || r_led[0]) begin
              w_pos_dir_nxt = DIR_LEFT;
            end else begin
              w_pos_dir_nxt = DIR_RIGHT;
            end
          end
        end
        MODE_BREATHE: begin
          if (!w_step) begin
            w_duty_nxt = r_duty;
          end else if (r_duty_dir == DIR_UP) begin
            if (r_duty != DUTY_MAX) begin
              w_duty_nxt = r_duty + DUTY_ONE;
            end else begin
              w_duty_nxt = r_duty;
            end
            if (r_duty >= (DUTY_MAX - DUTY_ONE)) begin
              w_duty_dir_nxt = DIR_DOWN;
            end else begin
              w_duty_dir_nxt = DIR_UP;
            end
          end else begin
            if (r_duty != '0) begin
              w_duty_nxt = r_duty - DUTY_ONE;
            end else begin
              w_duty_nxt = r_duty;
            end
            if (r_duty <= DUTY_ONE) begin
              w_duty_dir_nxt = DIR_UP;
            end else begin
              w_duty_dir_nxt = DIR_DOWN;
            end
          end
          // PWM output freezes with the counter when disabled.
          if (bus.en) begin
            w_led_nxt = {NUM_LED{(r_pwm < r_duty)}};
          end else begin
            w_led_nxt = r_led;
          end
        end
        default: begin
          w_led_nxt = r_led;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= MODE_BLINK;
      r_led      <= '0;
      r_tick     <= 1'b0;
      r_pos_dir  <= DIR_LEFT;
      r_duty     <= '0;
      r_duty_dir <= DIR_UP;
      r_pwm      <= '0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_led      <= w_led_nxt;
      r_tick     <= w_tick_nxt;
      r_pos_dir  <= w_pos_dir_nxt;
      r_duty     <= w_duty_nxt;
      r_duty_dir <= w_duty_dir_nxt;
      r_pwm      <= w_pwm_nxt;
    end
  end

  assign bus.led  = r_led;
  assign bus.tick = r_tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with short dividers (TICK_DIV=9, BREATHE_DIV=1, PWM_BITS=3).
module tb_led_pattern_gen;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  led_pattern_gen_if #(.NUM_LED(4)) bus ();

  led_pattern_gen #(
    .NUM_LED     (4),
    .TICK_DIV    (9),
    .BREATHE_DIV (1),
    .PWM_BITS    (3)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] chase_seq [4];
  logic [3:0] bounce_seq [12];
  logic [3:0] e_led;
  logic       e_tick;
  int         m_pwm;
  int         m_duty;
  int         m_cnt;
  bit         m_up;
  int         high_cnt;

  initial begin
    checks     = 0;
    errors     = 0;
    clk        = 1'b0;
    rst_n      = 1'b0;
    bus.en     = 1'b1;
    bus.mode   = 2'd0;
    chase_seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bounce_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                   4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

    // 1: reset state, then blink every 10 cycles
    step(2);
    check("rst_led", 32'(bus.led), 32'h0);
    check("rst_tick", 32'(bus.tick), 32'h0);
    rst_n = 1'b1;
    step(9);
    check("blink_c9_led", 32'(bus.led), 32'h0);
    check("blink_c9_tick", 32'(bus.tick), 32'h0);
    step(1);
    check("blink_c10_led", 32'(bus.led), 32'hF);
    check("blink_c10_tick", 32'(bus.tick), 32'h1);
    step(1);
    check("blink_c11_tick", 32'(bus.tick), 32'h0);
    step(9);
    check("blink_c20_led", 32'(bus.led), 32'h0);
    check("blink_c20_tick", 32'(bus.tick), 32'h1);

    // 2: chase, one TICK per 10-cycle step
    bus.mode = 2'd1;
    step(1);
    check("chase_init_led", 32'(bus.led), 32'h1);
    check("chase_init_tick", 32'(bus.tick), 32'h0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 10; c++) begin
        step(1);
        check("chase_tick", 32'(bus.tick), (c == 9) ? 32'h1 : 32'h0);
      end
      check("chase_led", 32'(bus.led), 32'(chase_seq[k]));
    end

    // 3: bounce, 12 steps
    bus.mode = 2'd2;
    step(1);
    check("bounce_init_led", 32'(bus.led), 32'h1);
    for (int k = 0; k < 12; k++) begin
      step(10);
      check("bounce_led", 32'(bus.led), 32'(bounce_seq[k]));
      check("bounce_tick", 32'(bus.tick), 32'h1);
    end

    // 4: breathe, duty 0..7..0 stepping every 2 cycles
    bus.mode = 2'd3;
    step(1);
    check("breathe_init_led", 32'(bus.led), 32'h0);
    check("breathe_init_tick", 32'(bus.tick), 32'h0);
    m_pwm    = 0;
    m_duty   = 0;
    m_cnt    = 0;
    m_up     = 1'b1;
    high_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      e_led  = (m_pwm < m_duty) ? 4'hF : 4'h0;
      e_tick = (m_cnt == 1);
      if (m_cnt == 1) begin
        m_cnt = 0;
        if (m_up) begin
          m_duty = m_duty + 1;
          if (m_duty == 7) m_up = 1'b0;
        end else begin
          m_duty = m_duty - 1;
          if (m_duty == 0) m_up = 1'b1;
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
      m_pwm = (m_pwm + 1) % 8;
      step(1);
      check("breathe_led", 32'(bus.led), 32'(e_led));
      check("breathe_tick", 32'(bus.tick), 32'(e_tick));
      if (bus.led == 4'hF) high_cnt++;
    end
    check("breathe_has_high", 32'(high_cnt > 0), 32'h1);

    // 5: chase with EN dropped at prescaler=5 for 20 cycles
    bus.mode = 2'd1;
    step(1);
    check("en_init_led", 32'(bus.led), 32'h1);
    step(5);
    bus.en = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      check("en_freeze_led", 32'(bus.led), 32'h1);
      check("en_freeze_tick", 32'(bus.tick), 32'h0);
    end
    bus.en = 1'b1;
    step(4);
    check("en_resume4_led", 32'(bus.led), 32'h1);
    check("en_resume4_tick", 32'(bus.tick), 32'h0);
    step(1);
    check("en_resume5_led", 32'(bus.led), 32'h2);
    check("en_resume5_tick", 32'(bus.tick), 32'h1);

    // 6a: mode change coincident with terminal count
    step(9);
    check("coinc_pre_led", 32'(bus.led), 32'h2);
    bus.mode = 2'd2;
    step(1);
    check("coinc_led", 32'(bus.led), 32'h1);
    check("coinc_tick", 32'(bus.tick), 32'h0);
    step(9);
    check("coinc_c9_led", 32'(bus.led), 32'h1);
    step(1);
    check("coinc_c10_led", 32'(bus.led), 32'h2);
    check("coinc_c10_tick", 32'(bus.tick), 32'h1);

    // 6b: reset pulse mid-chase with MODE=1 held
    bus.mode = 2'd1;
    step(1);
    check("rst2_init_led", 32'(bus.led), 32'h1);
    step(20);
    check("rst2_pre_led", 32'(bus.led), 32'h4);
    rst_n = 1'b0;
    #1;
    check("rst2_async_led", 32'(bus.led), 32'h0);
    check("rst2_async_tick", 32'(bus.tick), 32'h0);
    step(1);
    rst_n = 1'b1;
    check("rst2_rel_led", 32'(bus.led), 32'h0);
    step(1);
    check("rst2_post_led", 32'(bus.led), 32'h1);
    check("rst2_post_tick", 32'(bus.tick), 32'h0);
    step(10);
    check("rst2_step_led", 32'(bus.led), 32'h2);
    check("rst2_step_tick", 32'(bus.tick), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised LED driver: NUM_LED outputs, four selectable patterns (blink, chase, bounce, PWM breathe), runtime enable.
- An internal prescaler divides CLK down to a pattern step rate.
- Sits at board top level between the board clock/reset and the user LEDs.
- Supersedes the fixed 4-LED, 1 s all-toggle blinker.

Parameters:
- NUM_LED, 4, number of LED outputs (>= 2).
- TICK_DIV, 124999999, step-tick terminal count for blink/chase/bounce; period = TICK_DIV+1 CLK cycles (1 s at 125 MHz).
- BREATHE_DIV, 488280, step-tick terminal count in breathe mode (one duty step per BREATHE_DIV+1 cycles).
- PWM_BITS, 8, PWM counter and duty width.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  1 = patterns advance; 0 = freeze.
- MODE  in  2  pattern select: 0 blink, 1 chase, 2 bounce, 3 breathe.
- LED  out  NUM_LED  LED drive, registered.
- TICK  out  1  one-cycle pulse, high in the cycle the new LED pattern step first appears (modes 0-2) or the duty changes (mode 3).

Behaviour:
- Reset (RST_N=0, async): LED=0, TICK=0, prescaler=0, mode_q=0, pos-dir=left, duty=0, duty-dir=up, pwm_cnt=0.
- Mode capture: MODE is compared each cycle with the registered mode_q. On mismatch, the next edge does all of the following:
  - mode_q<=MODE, prescaler<=0, pwm_cnt<=0, TICK<=0.
  - Pattern init: blink LED=0; chase/bounce LED=1 (bit0), dir=left; breathe duty=0, duty-dir=up, LED=0.
  - Mode change applies regardless of EN and overrides a coincident tick; that tick is dropped.
- Prescaler:
  - Terminal = BREATHE_DIV when mode_q=3, else TICK_DIV.
  - Width = clog2(max(TICK_DIV,BREATHE_DIV)+1).
  - When EN=1: at terminal it wraps to 0 and asserts step; otherwise it increments.
  - When EN=0: holds; no step.
- Step (edge where prescaler==terminal and EN=1): TICK<=1 at that edge; otherwise TICK<=0.
  - Blink: LED <= ~LED.
  - Chase: rotate left by 1; bit NUM_LED-1 wraps to bit0.
  - Bounce: one-hot moves left while dir=left. On reaching bit NUM_LED-1, dir flips to right; it then moves right to bit0, where dir flips back to left. Endpoints are visited once per pass (sequence for 4 LEDs: 1,2,4,8,4,2,1,2...).
  - Breathe: duty-dir up gives duty+1; on reaching 2^PWM_BITS-1, duty-dir flips to down. Down gives duty-1; on reaching 0, duty-dir flips to up. No wrap or overflow.
- Breathe output:
  - pwm_cnt is a free-running PWM_BITS counter, incrementing every cycle while EN=1 and wrapping naturally.
  - All LED bits <= (pwm_cnt < duty), registered (1-cycle latency). duty=0 gives constant off.
  - EN=0 freezes pwm_cnt, so LED holds.
- Timing: after a mode init or reset release, the first step occurs terminal+1 cycles later; steps then repeat every terminal+1 cycles while EN=1.
- EN deassert mid-period: the prescaler count is retained, and the period resumes from the held value.
- Reset asserted mid-operation: all state returns to reset values immediately. If MODE!=0 at release, the first post-reset cycle performs the mode init.

Decomposition:
- Shared package led_pkg:
  - MODE_BLINK=2'd0, MODE_CHASE=2'd1, MODE_BOUNCE=2'd2, MODE_BREATHE=2'd3.
  - DIR_LEFT/DIR_RIGHT, DIR_UP/DIR_DOWN encodings.
- One sub-module, led_prescaler: terminal-count divider with TERM input, EN, synchronous CLR, STEP output.

Test Plan:
Bench params: NUM_LED=4, TICK_DIV=9, BREATHE_DIV=1, PWM_BITS=3.
1. Reset, MODE=0, EN=1 -> LED=0000. It toggles to 1111 at cycle 10 with TICK high that cycle, then 0000 at cycle 20.
2. MODE=1 -> next cycle LED=0001. Then 0010, 0100, 1000, 0001 every 10 cycles, one TICK per step.
3. MODE=2, 12 steps -> LED sequence 0001,0010,0100,1000,0100,0010,0001,0010,...
4. MODE=3 -> duty steps 0→7 then 7→0 every 2 cycles. At duty=3, LED high exactly 3 of every 8 cycles; at duty=0, LED constant 0.
5. MODE=1, EN=0 at prescaler=5 for 20 cycles -> LED and TICK frozen. After EN=1, the next step comes 5 cycles later.
6. Mode change coincident with terminal count; plus RST_N pulsed low mid-chase with MODE=1 held -> change wins: LED=0001 with no TICK. Reset: LED=0 immediately; LED=0001 one cycle after release.
